a_ctrls_poll: RTL
=================

// Module: a_ctrls_poll
// PURPOSE
//  Sequences the analog-controls link: on each poll tick, sends request "R\r" through the UART TX byte handshake.
//  Then waits for the frame decoder's frame_done with a timeout; retries up to MAX_RETRY times.
//  Latches the decoder's 7 bytes into a stable register set only on a completed frame.
//  Sits between the UART TX, the frame decoder and theremin consumers of the 7 control values.
// PARAMETERS
//  POLL_DIV     500000  clk cycles between poll ticks (100 Hz @ 50 MHz); >= 4
//  TIMEOUT_CYC  250000  cycles in WAIT before a request is declared lost; >= 2
//  MAX_RETRY    3       request attempts per tick before FAIL; 1..15
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous reset, active-high
//  enable        in   1      1 = polling active
//  tx_data       out  8      request byte to UART TX
//  tx_valid      out  1      tx_data valid
//  tx_ready      in   1      UART TX accepts byte this cycle
//  frame_done    in   1      1-cycle pulse from decoder: all 7 bytes stored
//  values_in     in   [0:6][7:0]  decoder value registers
//  values_out    out  [0:6][7:0]  last complete frame
//  values_valid  out  1      1-cycle pulse when values_out updated
//  link_ok       out  1      1 after a good frame, 0 after FAIL
//  err_cnt       out  8      FAIL events, saturates at 255
// BEHAVIOUR
//  Reset (sync, dominates all): state IDLE; tx_valid=0, tx_data=8'h00, values_out=0, values_valid=0,
//   link_ok=0, err_cnt=0; tick counter=0, timeout counter=0, retry=0.
//  Tick counter: free-running 0..POLL_DIV-1 while enable=1, held at 0 while enable=0.
//   Tick is asserted for the cycle in which the count equals POLL_DIV-1.
//   Ticks arriving in any state other than IDLE are dropped; there is no queueing.
//  TX handshake: a byte transfers on a clk edge with tx_valid & tx_ready.
//   tx_valid, once high, stays high with tx_data stable until the transfer; never withdrawn (incl. enable drop).
//  FSM:
//   IDLE:   tick & enable -> SEND0 (tx_data=8'h52, tx_valid=1 registered on the transition).
//   SEND0:  on transfer -> SEND1 (tx_data=8'h0D, tx_valid stays 1).
//   SEND1:  on transfer -> tx_valid=0; WAIT with timeout counter=0.
//   WAIT:   frame_done -> LATCH.
//           else counter==TIMEOUT_CYC-1 -> retry+1; if retry+1<MAX_RETRY -> SEND0, else FAIL.
//           enable=0 -> IDLE (retry=0).
//   LATCH:  values_out<=values_in, values_valid=1 (this cycle only), link_ok<=1, retry<=0 -> IDLE.
//   FAIL:   link_ok<=0, err_cnt<=sat(err_cnt+1), retry<=0 -> IDLE.
//  SEND0/SEND1 complete even if enable drops; the next state is then IDLE instead of WAIT.
//  frame_done outside WAIT is stale and ignored; values_out is unchanged.
//  frame_done and timeout in the same WAIT cycle: frame_done wins -> LATCH.
//  Latency: frame_done (WAIT) -> values_out/values_valid visible 2 edges later (WAIT->LATCH, LATCH reg).
//  err_cnt at 255 stays 255; link_ok is unaffected by saturation.
// CONFIGURATION
//  Macro A_CTRLS_POLL_CHANGE_EN defined:
//   - Adds output changed[6:0].
//   - In LATCH, changed[i]=(values_in[i]!=values_out[i]), registered with values_out.
//   - changed holds until the next LATCH; reset value 0.
//  Undefined: no changed port, no compare logic.
// TESTING (bench params POLL_DIV=100, TIMEOUT_CYC=50, MAX_RETRY=2)
//  1 enable=1, tx_ready=1: first tick at cycle 99 -> TX sees 8'h52 then 8'h0D on consecutive edges.
//  2 frame_done 10 cycles after the last TX byte, values_in=01..07 -> values_out=01..07,
//    values_valid pulses 1 cycle, link_ok=1.
//  3 No frame_done -> request resent after 50 cycles; second timeout -> FAIL, link_ok=0, err_cnt=1,
//    no further TX until the next tick.
//  4 tx_ready=0 for 20 cycles during SEND0, enable dropped meanwhile -> tx_valid/tx_data=8'h52 held
//    stable, both bytes sent, then IDLE with no WAIT.
//  5 frame_done in IDLE with values_in=FF -> values_out unchanged, no values_valid.
//    frame_done coincident with timeout -> LATCH.
//  6 reset asserted in WAIT and in SEND1 -> next edge: all outputs at reset values, tx_valid=0;
//    with A_CTRLS_POLL_CHANGE_EN, changing only byte 3 -> changed=7'b0001000.

Source files
------------

// File: rtl/a_ctrls_poll_if.sv
// Poll-side link bundle: UART TX byte handshake plus the frame decoder's done pulse and values.
interface a_ctrls_poll_if;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            frame_done;
    logic [0:6][7:0] values_in;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  frame_done,
        input  values_in
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output frame_done,
        output values_in
    );
endinterface

// File: rtl/a_ctrls_poll.sv
// Analog-controls poller: sends "R\r" per tick, waits for a frame with timeout/retry, latches values.
// Optional macro A_CTRLS_POLL_CHANGE_EN adds the per-byte o_changed flags.
module a_ctrls_poll #(
    parameter int unsigned POLL_DIV    = 500000,
    parameter int unsigned TIMEOUT_CYC = 250000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_enable,
    a_ctrls_poll_if.master  if_link,
    output logic [0:6][7:0] o_values_out,
    output logic            o_values_valid,
    output logic            o_link_ok,
`ifdef A_CTRLS_POLL_CHANGE_EN
    output logic [6:0]      o_changed,
`endif
    output logic [7:0]      o_err_cnt
);
    localparam int unsigned TickW = $clog2(POLL_DIV);
    localparam int unsigned TimeW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {StIdle, StSend0, StSend1, StWait, StLatch, StFail} state_e;

    state_e          r_state;
    logic [TickW-1:0] r_tick_cnt;
    logic [TimeW-1:0] r_to_cnt;
    logic [3:0]      r_retry;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
    logic [0:6][7:0] r_values_out;
    logic            r_values_valid;
    logic            r_link_ok;
    logic [7:0]      r_err_cnt;
`ifdef A_CTRLS_POLL_CHANGE_EN
    logic [6:0]      r_changed;
`endif

    logic            w_tick;
    logic            w_xfer;
    logic            w_timeout;
    logic [3:0]      w_retry_inc;

    assign w_tick      = i_enable && (r_tick_cnt == TickW'(POLL_DIV - 1));
    assign w_xfer      = r_tx_valid && if_link.tx_ready;
    assign w_timeout   = (r_to_cnt == TimeW'(TIMEOUT_CYC - 1));
    assign w_retry_inc = r_retry + 4'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TickW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_to_cnt       <= '0;
            r_retry        <= '0;
            r_tx_data      <= 8'h00;
            r_tx_valid     <= 1'b0;
            r_values_out   <= '0;
            r_values_valid <= 1'b0;
            r_link_ok      <= 1'b0;
            r_err_cnt      <= 8'h00;
`ifdef A_CTRLS_POLL_CHANGE_EN
            r_changed      <= '0;
`endif
        end else begin
            r_values_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_tick) begin
                        r_state    <= StSend0;
                        r_tx_data  <= 8'h52;
                        r_tx_valid <= 1'b1;
                    end
                end
                StSend0: begin
                    if (w_xfer) begin
                        r_state   <= StSend1;
                        r_tx_data <= 8'h0D;
                    end
                end
                StSend1: begin
                    // A request is never cut short; an enable drop only skips the wait.
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_to_cnt   <= '0;
                        if (i_enable) begin
                            r_state <= StWait;
                        end else begin
                            r_state <= StIdle;
                            r_retry <= '0;
                        end
                    end
                end
                StWait: begin
                    if (if_link.frame_done) begin
                        r_state <= StLatch;
                    end else if (w_timeout) begin
                        r_retry <= w_retry_inc;
                        if (w_retry_inc < 4'(MAX_RETRY)) begin
                            r_state    <= StSend0;
                            r_tx_data  <= 8'h52;
                            r_tx_valid <= 1'b1;
                        end else begin
                            r_state <= StFail;
                        end
                    end else if (!i_enable) begin
                        r_state <= StIdle;
                        r_retry <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TimeW'(1);
                    end
                end
                StLatch: begin
`ifdef A_CTRLS_POLL_CHANGE_EN
                    for (int i = 0; i < 7; i++) begin
                        r_changed[i] <= (if_link.values_in[i] != r_values_out[i]);
                    end
`endif
                    r_values_out   <= if_link.values_in;
                    r_values_valid <= 1'b1;
                    r_link_ok      <= 1'b1;
                    r_retry        <= '0;
                    r_state        <= StIdle;
                end
                StFail: begin
                    r_link_ok <= 1'b0;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    r_retry <= '0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign if_link.tx_data  = r_tx_data;
    assign if_link.tx_valid = r_tx_valid;
    assign o_values_out     = r_values_out;
    assign o_values_valid   = r_values_valid;
    assign o_link_ok        = r_link_ok;
    assign o_err_cnt        = r_err_cnt;
`ifdef A_CTRLS_POLL_CHANGE_EN
    assign o_changed        = r_changed;
`endif
endmodule
